// File: rtl/avg_pool2x2_ctrl.sv
// avg_pool2x2_ctrl: sequences a shared 4-input averaging adder for 2x2 average pooling of a raster stream.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module avg_pool2x2_ctrl #(
  parameter int pDATA_W = 8,
  parameter int pIMG_W  = 32,
  parameter int pIMG_H  = 32
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    istart,
  input  logic                    ivalid,
  input  logic [pDATA_W-1:0]      idata,
  output logic                    oready,
  output logic                    oadd_en,
  output logic [3:0][pDATA_W-1:0] oadd_data,
  input  logic [2*pDATA_W-1:0]    iadd_data,
  output logic                    ovalid,
  output logic [2*pDATA_W-1:0]    odata,
  output logic                    obusy,
  output logic                    oframe_done
);

  localparam int c_COL_W = $clog2(pIMG_W);
  localparam int c_ROW_W = $clog2(pIMG_H);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(pIMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(pIMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_COL_W-1:0]   r_col;
  logic [c_ROW_W-1:0]   r_row;
  logic [1:0]           r_drain_cnt;
  logic [pDATA_W-1:0]   r_hold;
  logic [pDATA_W-1:0]   r_lb [pIMG_W];
  logic [2:0]           r_vp;

  logic                 w_hs;
  logic                 w_fire;
  logic                 w_last_col;
  logic                 w_last_row;
  logic [c_COL_W-1:0]   w_col_prev;

  assign w_hs       = (r_state == S_RUN) && ivalid;
  assign w_fire     = w_hs && r_row[0] && r_col[0];
  assign w_last_col = (r_col == c_COL_LAST);
  assign w_last_row = (r_row == c_ROW_LAST);
  assign w_col_prev = r_col - c_COL_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    oready      = 1'b0;
    oadd_en     = 1'b1;
    obusy       = 1'b1;
    oframe_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        oadd_en = 1'b0;
        obusy   = 1'b0;
        if (istart) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        oready = 1'b1;
        if (w_hs && w_last_col && w_last_row) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Three drain cycles let the final window reach ovalid before DONE.
        if (r_drain_cnt == 2'd2) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        oframe_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oadd_data = '0;
    if (w_fire) begin
      oadd_data[0] = r_lb[w_col_prev];
      oadd_data[1] = r_lb[r_col];
      oadd_data[2] = r_hold;
      oadd_data[3] = idata;
    end
  end

  assign ovalid = r_vp[2];
  assign odata  = iadd_data;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_drain_cnt <= '0;
      r_hold      <= '0;
      r_vp        <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && istart) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_hs) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end

      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;

      if (w_hs && r_row[0] && !r_col[0]) r_hold <= idata;

      // Bubbles shift through as zeros so they never raise ovalid.
      if (oadd_en) r_vp <= {r_vp[1:0], w_fire};
    end
  end

  always_ff @(posedge iclk) begin
    if (w_hs && !r_row[0]) r_lb[r_col] <= idata;
  end

endmodule

`default_nettype wire

// File: tb/tb_avg_pool2x2_ctrl.sv
// tb_avg_pool2x2_ctrl: randomized and directed frames checked cycle by cycle against a behavioural pooling model.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_avg_pool2x2_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b1;
  logic              istart = 1'b0;
  logic              ivalid = 1'b0;
  logic [DW-1:0]     idata  = '0;
  logic              oready, oadd_en, ovalid, obusy, oframe_done;
  logic [3:0][DW-1:0] oadd_data;
  logic [2*DW-1:0]   iadd_data, odata;
  logic [2*DW-1:0]   a0 = '0, a1 = '0, a2 = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avg_pool2x2_ctrl #(.pDATA_W(DW), .pIMG_W(W), .pIMG_H(H)) dut (
    .iclk(clk), .irst_n(rst_n), .istart(istart), .ivalid(ivalid), .idata(idata),
    .oready(oready), .oadd_en(oadd_en), .oadd_data(oadd_data), .iadd_data(iadd_data),
    .ovalid(ovalid), .odata(odata), .obusy(obusy), .oframe_done(oframe_done)
  );

  // Three-stage averaging adder standing in for add2_2.
  always @(posedge clk) begin
    if (oadd_en) begin
      a0 <= 16'((32'(oadd_data[0]) + 32'(oadd_data[1]) + 32'(oadd_data[2]) + 32'(oadd_data[3])) / 4);
      a1 <= a0;
      a2 <= a1;
    end
  end
  assign iadd_data = a2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Model: mode 0 idle, 1 accepting pixels, 2 post-frame (m_post = cycles since last pixel).
  int   m_mode = 0, m_pix = 0, m_post = 0, m_cyc = 0, mr = 0, mc = 0;
  int   m_img [H][W];
  int   q_cyc[$], q_val[$], got_q[$];
  int   n_done = 0;
  logic exp_valid;
  logic [4*DW-1:0] exp_add;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pix = 0; m_post = 0;
      q_cyc.delete(); q_val.delete();
    end else begin
      mr = m_pix / W;
      mc = m_pix % W;
      exp_add = '0;
      if (m_mode == 1 && ivalid && (mr % 2 == 1) && (mc % 2 == 1))
        exp_add = {idata, DW'(m_img[mr][mc-1]), DW'(m_img[mr-1][mc]), DW'(m_img[mr-1][mc-1])};

      chk("oready", oready, m_mode == 1);
      chk("obusy", obusy, m_mode != 0);
      chk("oadd_en", oadd_en, m_mode != 0);
      chk("oframe_done", oframe_done, m_mode == 2 && m_post == 3);
      chk("oadd_data", oadd_data, exp_add);
      exp_valid = (q_cyc.size() > 0) && (q_cyc[0] == m_cyc);
      chk("ovalid", ovalid, exp_valid);
      if (exp_valid) begin
        chk("odata", odata, q_val[0]);
        void'(q_cyc.pop_front());
        void'(q_val.pop_front());
      end
      if (ovalid) got_q.push_back(int'(odata));
      if (oframe_done) n_done++;

      // Predict what the coming rising edge does.
      case (m_mode)
        0: if (istart) begin m_mode = 1; m_pix = 0; end
        1: if (ivalid) begin
          m_img[mr][mc] = int'(idata);
          if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            q_cyc.push_back(m_cyc + 3);
            q_val.push_back((m_img[mr-1][mc-1] + m_img[mr-1][mc] + m_img[mr][mc-1] + m_img[mr][mc]) / 4);
          end
          m_pix++;
          if (m_pix == W * H) begin m_mode = 2; m_post = 0; end
        end
        default: begin
          m_post++;
          if (m_post == 4) m_mode = 0;
        end
      endcase
      m_cyc++;
    end
  end

  task automatic start_frame();
    istart = 1'b1;
    @(posedge clk); #2;
    istart = 1'b0;
  endtask

  // kind: 0 constant 255, 1 ramp, 2 random; gap: 0 none, 1 alternate, 2 random.
  task automatic send(input int kind, input int gap, input int n_pix, input bit junk_start);
    int idx = 0;
    int budget = 0;
    bit hs;
    while (idx < n_pix) begin
      if (budget > 300) begin
        n_chk++; n_err++;
        $display("FAIL send_timeout: handshakes %0d required %0d", idx, n_pix);
        ivalid = 1'b0; istart = 1'b0;
        return;
      end
      ivalid = (gap == 0) ? 1'b1 : (gap == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
      idata  = (kind == 0) ? DW'(255) : (kind == 1) ? DW'(idx + 1) : DW'($urandom_range(0, 255));
      if (junk_start) istart = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      hs = ivalid && oready;
      @(posedge clk); #2;
      if (hs) begin
        idx++;
        if (!junk_start) istart = 1'b0;
      end
      budget++;
    end
    ivalid = 1'b0;
    istart = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic check_frames(input string nm, input int kind, input int frames);
    int ramp_exp [4] = '{3, 5, 11, 13};
    chk({nm, "_count"}, got_q.size(), 4 * frames);
    chk({nm, "_done"}, n_done, frames);
    for (int i = 0; i < got_q.size() && i < 4 * frames; i++)
      chk({nm, "_value"}, got_q[i], (kind == 0) ? 255 : ramp_exp[i % 4]);
    got_q.delete();
    n_done = 0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_oready"}, oready, 0);
    chk({nm, "_oadd_en"}, oadd_en, 0);
    chk({nm, "_oadd_data"}, oadd_data, 0);
    chk({nm, "_ovalid"}, ovalid, 0);
    chk({nm, "_obusy"}, obusy, 0);
    chk({nm, "_oframe_done"}, oframe_done, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // ivalid while idle must not be consumed.
    ivalid = 1'b1; idata = 8'd77;
    repeat (3) @(posedge clk);
    #2 ivalid = 1'b0;
    chk("idle_no_output", got_q.size(), 0);

    start_frame(); send(0, 0, W * H, 1'b0); settle();
    check_frames("constant", 0, 1);

    start_frame(); send(1, 0, W * H, 1'b0); settle();
    check_frames("ramp", 1, 1);

    start_frame(); send(1, 1, W * H, 1'b1); settle();
    check_frames("ramp_gaps", 1, 1);

    start_frame(); send(1, 0, 6, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    settle();
    chk("midreset_no_output", got_q.size(), 0);
    chk("midreset_no_done", n_done, 0);
    start_frame(); send(1, 0, W * H, 1'b0); settle();
    check_frames("after_reset", 1, 1);

    start_frame(); send(1, 0, W * H, 1'b0);
    istart = 1'b1;
    send(1, 0, W * H, 1'b0); settle();
    check_frames("back_to_back", 1, 2);

    for (int f = 0; f < 4; f++) begin
      start_frame(); send(2, 2, W * H, 1'b1); settle();
      chk("random_count", got_q.size(), 4);
      chk("random_done", n_done, 1);
      got_q.delete();
      n_done = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
